// File: rtl/not16_checker_pkg.sv
// ============================================================================
// Module      : not16_checker_pkg
// Description : Shared state encoding, default sizes and saturating increment
//               for the Not16 response checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package not16_checker_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counters are passed through a 32-bit carrier so one function serves any CNT_W.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/not16_checker_not16.sv
// ============================================================================
// Module      : not16_checker_not16
// Description : Golden Not16 model; produces the expected response for stim.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module not16_checker_not16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = ~i_a;

endmodule

`default_nettype wire

// File: rtl/not16_checker.sv
// ============================================================================
// Module      : not16_checker
// Description : Compares DUT responses against bitwise-NOT of the stimulus,
//               counts pass/fail and captures the first failing vector.
//               Optional per-bit compare mask: NOT16_CHECKER_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module not16_checker
    import not16_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] resp,
`ifdef NOT16_CHECKER_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail_stim,
    output logic [WIDTH-1:0] first_fail_resp
);

    localparam logic [31:0] c_cnt_max = 32'((64'd1 << CNT_W) - 64'd1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_done;
    logic               w_start_acc;
    logic [WIDTH-1:0]   w_expected;
    logic               w_match;
    logic               w_compare;

    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic               r_fail_seen;
    logic [WIDTH-1:0]   r_ff_stim;
    logic [WIDTH-1:0]   r_ff_resp;

    not16_checker_not16 #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a (stim),
        .o_y (w_expected)
    );

`ifdef NOT16_CHECKER_MASK_EN
    assign w_match = (((resp ^ w_expected) & mask) == '0);
`else
    assign w_match = (resp == w_expected);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_acc = 1'b1;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (valid && last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_acc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Only RUN compares; the last vector is counted on the edge that leaves RUN.
    assign w_compare = (r_state == ST_RUN) && valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_stim   <= '0;
            r_ff_resp   <= '0;
        end else if (w_start_acc) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_stim   <= '0;
            r_ff_resp   <= '0;
        end else if (w_compare) begin
            if (w_match) begin
                r_pass_cnt <= CNT_W'(sat_inc(32'(r_pass_cnt), c_cnt_max));
            end else begin
                r_fail_cnt <= CNT_W'(sat_inc(32'(r_fail_cnt), c_cnt_max));
                if (!r_fail_seen) begin
                    r_fail_seen <= 1'b1;
                    r_ff_stim   <= stim;
                    r_ff_resp   <= resp;
                end
            end
        end
    end

    assign busy            = w_busy;
    assign done            = w_done;
    assign pass_cnt        = r_pass_cnt;
    assign fail_cnt        = r_fail_cnt;
    assign fail_seen       = r_fail_seen;
    assign first_fail_stim = r_ff_stim;
    assign first_fail_resp = r_ff_resp;

endmodule

`default_nettype wire

// File: tb/tb_not16_checker.sv
// ============================================================================
// Module      : tb_not16_checker
// Description : Self-checking bench for not16_checker (CNT_W=8 and CNT_W=2).
//               Mask scenario built when NOT16_CHECKER_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_not16_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic [15:0] stim = '0;
    logic [15:0] resp = '0;
    logic [15:0] mask = 16'hFFFF;

    logic        busy, done, fail_seen;
    logic [7:0]  pass_cnt, fail_cnt;
    logic [15:0] ffs, ffr;
    logic        s_busy, s_done, s_seen;
    logic [1:0]  s_pass, s_fail;
    logic [15:0] s_ffs, s_ffr;

    int errors = 0;
    int checks = 0;

    // Reference model: run/done flags, unbounded counts, first-failure record.
    bit          m_run, m_done, m_seen;
    int          m_pass, m_fail;
    logic [15:0] m_ffs, m_ffr;

    always #5 clk = ~clk;

    not16_checker #(.WIDTH(16), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
        .stim(stim), .resp(resp),
`ifdef NOT16_CHECKER_MASK_EN
        .mask(mask),
`endif
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .first_fail_stim(ffs), .first_fail_resp(ffr)
    );

    not16_checker #(.WIDTH(16), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
        .stim(stim), .resp(resp),
`ifdef NOT16_CHECKER_MASK_EN
        .mask(mask),
`endif
        .busy(s_busy), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
        .fail_seen(s_seen), .first_fail_stim(s_ffs), .first_fail_resp(s_ffr)
    );

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_clear();
        m_run = 0; m_done = 0; m_seen = 0;
        m_pass = 0; m_fail = 0; m_ffs = '0; m_ffr = '0;
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit st, input bit v, input bit l,
                        input logic [15:0] s, input logic [15:0] r);
        logic [15:0] eff_mask;
        start = st; valid = v; last = l; stim = s; resp = r;
`ifdef NOT16_CHECKER_MASK_EN
        eff_mask = mask;
`else
        eff_mask = 16'hFFFF;
`endif
        @(posedge clk);
        if (st && !m_run) begin
            m_run = 1; m_done = 0; m_seen = 0;
            m_pass = 0; m_fail = 0; m_ffs = '0; m_ffr = '0;
        end else if (m_run && v) begin
            if (((r ^ ~s) & eff_mask) == 16'h0) m_pass++;
            else begin
                m_fail++;
                if (!m_seen) begin m_seen = 1; m_ffs = s; m_ffr = r; end
            end
            if (l) begin m_run = 0; m_done = 1; end
        end
        #1;
        start = 0; valid = 0; last = 0;
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b1;
        #3;
        checks++;
        if ({busy, done, fail_seen, pass_cnt, fail_cnt, ffs, ffr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b pass=%0d fail=%0d seen=%b expected all zero",
                     busy, done, pass_cnt, fail_cnt, fail_seen);
        end
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 1, 16'h1234, 16'hEDCB);
        checks++;
        if (busy !== 1'b0 || pass_cnt !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_ignored: got busy=%b pass=%0d done=%b expected 0 0 0",
                     busy, pass_cnt, done);
        end
    endtask

    task automatic test_normal_run();
        logic [15:0] vec [5] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
        step(1, 0, 0, '0, '0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 5; i++) step(0, 1, (i == 4), vec[i], ~vec[i]);
        checks++;
        if (pass_cnt !== 8'd5 || fail_cnt !== 8'd0 || fail_seen !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_run: got pass=%0d fail=%0d seen=%b done=%b busy=%b expected 5 0 0 1 0",
                     pass_cnt, fail_cnt, fail_seen, done, busy);
        end
    endtask

    task automatic test_ignored_inputs();
        step(0, 1, 1, 16'h0F0F, 16'h0000);
        step(0, 1, 0, 16'h0F0F, 16'hF0F0);
        checks++;
        if (pass_cnt !== 8'd5 || fail_cnt !== 8'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_valid_ignored: got pass=%0d fail=%0d done=%b expected 5 0 1",
                     pass_cnt, fail_cnt, done);
        end
        step(1, 0, 0, '0, '0);
        step(1, 1, 0, 16'h00FF, 16'hFF00);
        step(0, 0, 1, 16'h0001, 16'h0000);
        checks++;
        if (pass_cnt !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_start_ignored: got pass=%0d busy=%b done=%b expected 1 1 0",
                     pass_cnt, busy, done);
        end
        step(0, 1, 1, 16'h8001, 16'h7FFE);
        checks++;
        if (pass_cnt !== 8'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL run_after_ignored: got pass=%0d done=%b expected 2 1", pass_cnt, done);
        end
    endtask

    task automatic test_first_fail();
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'hAAAA, 16'h5554);
        step(0, 1, 1, 16'h1234, 16'h0000);
        checks++;
        if (fail_cnt !== 8'd2 || pass_cnt !== 8'd0 || fail_seen !== 1'b1) begin
            errors++;
            $display("FAIL first_fail_counts: got fail=%0d pass=%0d seen=%b expected 2 0 1",
                     fail_cnt, pass_cnt, fail_seen);
        end
        checks++;
        if (ffs !== 16'hAAAA || ffr !== 16'h5554) begin
            errors++;
            $display("FAIL first_fail_capture: got stim=%h resp=%h expected aaaa 5554", ffs, ffr);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] s;
            s = 16'($urandom);
            step(0, 1, (i == 5), s, ~s);
        end
        checks++;
        if (s_pass !== 2'd3 || s_fail !== 2'd0 || s_done !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got pass=%0d fail=%0d done=%b expected 3 0 1", s_pass, s_fail, s_done);
        end
        checks++;
        if (pass_cnt !== 8'd6) begin
            errors++; $display("FAIL wide_count: got %0d expected 6", pass_cnt);
        end
        step(1, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, (i == 4), 16'h0101, 16'h0000);
        checks++;
        if (s_fail !== 2'd3 || s_pass !== 2'd0 || fail_cnt !== 8'd5) begin
            errors++;
            $display("FAIL fail_saturation: got sat_fail=%0d sat_pass=%0d fail=%0d expected 3 0 5",
                     s_fail, s_pass, fail_cnt);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'h1111, 16'hEEEE);
        step(0, 1, 0, 16'h2222, 16'h0000);
        step(0, 1, 0, 16'h3333, 16'hCCCC);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, fail_seen, pass_cnt, fail_cnt, ffs, ffr, s_busy, s_pass, s_fail} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b pass=%0d fail=%0d seen=%b stim=%h expected all zero",
                     busy, pass_cnt, fail_cnt, fail_seen, ffs);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'h5A5A, 16'hA5A5);
        step(0, 1, 1, 16'hC001, 16'h3FFF);
        checks++;
        if (pass_cnt !== 8'd1 || fail_cnt !== 8'd1 || ffs !== 16'hC001 || ffr !== 16'h3FFF || done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run: got pass=%0d fail=%0d stim=%h resp=%h done=%b expected 1 1 c001 3fff 1",
                     pass_cnt, fail_cnt, ffs, ffr, done);
        end
    endtask

`ifdef NOT16_CHECKER_MASK_EN
    task automatic test_mask();
        mask = 16'h00FF;
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'h0000, 16'h00FF);
        checks++;
        if (pass_cnt !== 8'd1 || fail_cnt !== 8'd0) begin
            errors++; $display("FAIL mask_pass: got pass=%0d fail=%0d expected 1 0", pass_cnt, fail_cnt);
        end
        step(0, 1, 1, 16'h0000, 16'hFFFE);
        checks++;
        if (fail_cnt !== 8'd1 || ffr !== 16'hFFFE || ffs !== 16'h0000) begin
            errors++;
            $display("FAIL mask_fail: got fail=%0d resp=%h stim=%h expected 1 fffe 0000", fail_cnt, ffr, ffs);
        end
        mask = 16'h0000;
        step(1, 0, 0, '0, '0);
        step(0, 1, 1, 16'h1234, 16'h1234);
        checks++;
        if (pass_cnt !== 8'd1 || fail_cnt !== 8'd0) begin
            errors++; $display("FAIL mask_zero: got pass=%0d fail=%0d expected 1 0", pass_cnt, fail_cnt);
        end
        mask = 16'hFFFF;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [15:0] s, r;
            bit st, v, l;
            s  = 16'($urandom);
            r  = ~s;
            if ($urandom_range(0, 3) == 0) r = r ^ (16'h1 << $urandom_range(0, 15));
            st = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 9) < 7);
            l  = ($urandom_range(0, 9) < 2);
`ifdef NOT16_CHECKER_MASK_EN
            mask = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
`endif
            step(st, v, l, s, r);
            checks++;
            if (busy !== m_run || done !== m_done || s_busy !== m_run || s_done !== m_done) begin
                errors++;
                $display("FAIL rand_state[%0d]: got busy=%b done=%b expected %b %b", n, busy, done, m_run, m_done);
            end
            checks++;
            if (pass_cnt !== 8'(sat(m_pass, 255)) || fail_cnt !== 8'(sat(m_fail, 255))) begin
                errors++;
                $display("FAIL rand_counts[%0d]: got pass=%0d fail=%0d expected %0d %0d",
                         n, pass_cnt, fail_cnt, sat(m_pass, 255), sat(m_fail, 255));
            end
            checks++;
            if (s_pass !== 2'(sat(m_pass, 3)) || s_fail !== 2'(sat(m_fail, 3))) begin
                errors++;
                $display("FAIL rand_sat_counts[%0d]: got pass=%0d fail=%0d expected %0d %0d",
                         n, s_pass, s_fail, sat(m_pass, 3), sat(m_fail, 3));
            end
            checks++;
            if (fail_seen !== m_seen || ffs !== m_ffs || ffr !== m_ffr) begin
                errors++;
                $display("FAIL rand_capture[%0d]: got seen=%b stim=%h resp=%h expected %b %h %h",
                         n, fail_seen, ffs, ffr, m_seen, m_ffs, m_ffr);
            end
        end
`ifdef NOT16_CHECKER_MASK_EN
        mask = 16'hFFFF;
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_normal_run();
        test_ignored_inputs();
        test_first_fail();
        test_saturation();
        test_async_reset();
`ifdef NOT16_CHECKER_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
